// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding, PC width
// and the fixed branch-target LUT contents.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  localparam int unsigned PC_W = 10;

  // Entry 1 is a backward offset of 4 once truncated to the PC width.
  localparam int TARG_0 = 0;
  localparam int TARG_1 = -4;
  localparam int TARG_2 = 16;
  localparam int TARG_3 = 32;

endpackage

// File: rtl/fetch_unit_target_lut.sv
// Branch-target LUT: 2-bit index to a PW-bit absolute address or signed offset.
module target_lut
  import fetch_unit_pkg::*;
#(
  parameter int unsigned PW = PC_W
) (
  input  logic [1:0]    idx,
  output logic [PW-1:0] targ
);

  always_comb begin
    targ = '0;
    unique case (idx)
      2'd0: targ = PW'(TARG_0);
      2'd1: targ = PW'(TARG_1);
      2'd2: targ = PW'(TARG_2);
      2'd3: targ = PW'(TARG_3);
      default: targ = '0;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register and IDLE/RUN/DONE fetch sequencer for the 9-bit core.
// Optional RUN-cycle counter enabled by defining FETCH_CYCLE_COUNT_EN.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned    PW        = PC_W,
  parameter logic [PW-1:0]  StartAddr = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic          Branch,
  input  logic          BranchEn,
  input  logic [1:0]    PCTarg,
  input  logic          Zero,
  input  logic          Ack,
`ifdef FETCH_CYCLE_COUNT_EN
  output logic [15:0]   CycleCnt,
`endif
  output logic [PW-1:0] ProgCtr,
  output logic          Busy,
  output logic          Done
);

  fetch_state_t  state, state_n;
  logic [PW-1:0] pc, pc_n;
  logic [PW-1:0] targ;

  target_lut #(.PW(PW)) u_lut (
    .idx  (PCTarg),
    .targ (targ)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= StartAddr;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    unique case (state)
      IDLE, DONE: begin
        if (Start) begin
          state_n = RUN;
          pc_n    = StartAddr;
        end
      end
      RUN: begin
        // Ack freezes PC on the halt instruction itself.
        if (Ack)
          state_n = DONE;
        else if (Branch)
          pc_n = targ;
        else if (BranchEn && Zero)
          pc_n = pc + targ;
        else
          pc_n = pc + PW'(1);
      end
      default: begin
        state_n = IDLE;
        pc_n    = StartAddr;
      end
    endcase
  end

  assign ProgCtr = pc;
  assign Busy    = (state == RUN);
  assign Done    = (state == DONE);

`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] cnt;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      cnt <= '0;
    else if (state != RUN && Start)
      cnt <= '0;
    else if (state == RUN && cnt != '1)
      cnt <= cnt + 16'd1;
  end

  assign CycleCnt = cnt;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed scoreboard bench for fetch_unit (default PW = 10, StartAddr = 0).
module tb_fetch_unit;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       Start = 1'b0;
  logic       Branch = 1'b0;
  logic       BranchEn = 1'b0;
  logic [1:0] PCTarg = 2'd0;
  logic       Zero = 1'b0;
  logic       Ack = 1'b0;
  logic [9:0] ProgCtr;
  logic       Busy;
  logic       Done;
`ifdef FETCH_CYCLE_COUNT_EN
  logic [15:0] CycleCnt;
`endif

  fetch_unit #(.PW(10), .StartAddr(10'd0)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Start    (Start),
    .Branch   (Branch),
    .BranchEn (BranchEn),
    .PCTarg   (PCTarg),
    .Zero     (Zero),
    .Ack      (Ack),
`ifdef FETCH_CYCLE_COUNT_EN
    .CycleCnt (CycleCnt),
`endif
    .ProgCtr  (ProgCtr),
    .Busy     (Busy),
    .Done     (Done)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] pc;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int unsigned total  = 0;
  int unsigned passed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Drive one cycle of decoder inputs, queue the post-edge expectation,
  // then compare #1 after the rising edge.
  task automatic step(input logic st, input logic br, input logic be, input logic [1:0] tg,
                      input logic z, input logic ak,
                      input logic [9:0] epc, input logic eb, input logic ed);
    exp_t e;
    Start = st; Branch = br; BranchEn = be; PCTarg = tg; Zero = z; Ack = ak;
    sb.push_back('{pc: epc, busy: eb, done: ed});
    @(posedge Clk);
    #1;
    e = sb.pop_front();
    chk("pc",   {22'd0, ProgCtr}, {22'd0, e.pc});
    chk("busy", {31'd0, Busy},    {31'd0, e.busy});
    chk("done", {31'd0, Done},    {31'd0, e.done});
  endtask

  task automatic plain(input logic [9:0] epc);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, epc, 1'b1, 1'b0);
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_pc",   {22'd0, ProgCtr}, 32'd0);
    chk("rst_busy", {31'd0, Busy},    32'd0);
    chk("rst_done", {31'd0, Done},    32'd0);
    @(posedge Clk); #1;
    Reset = 1'b1;

    // Idle: decoder inputs ignored without Start
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    for (int unsigned i = 1; i <= 7; i++) plain(10'(i));
    // Jump at PC 7 via LUT[2]
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0, 10'd16, 1'b1, 1'b0);
    for (int unsigned i = 17; i <= 20; i++) plain(10'(i));
    // Taken relative branch at 20, offset -4
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 10'd16, 1'b1, 1'b0);
    for (int unsigned i = 17; i <= 20; i++) plain(10'(i));
    // Not taken at 20
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 10'd21, 1'b1, 1'b0);
    // Start mid-RUN ignored
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd22, 1'b1, 1'b0);
    for (int unsigned i = 23; i <= 37; i++) plain(10'(i));

    // Asynchronous reset mid-cycle at PC 37
    #2;
    Reset = 1'b0;
    #1;
    chk("arst_pc",   {22'd0, ProgCtr}, 32'd0);
    chk("arst_busy", {31'd0, Busy},    32'd0);
    chk("arst_done", {31'd0, Done},    32'd0);
    #1;
    Reset = 1'b1;
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b0, 1'b0);

    // Wrap-around: jump to 1020, run past 1023
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0, 10'd1020, 1'b1, 1'b0);
    plain(10'd1021);
    plain(10'd1022);
    plain(10'd1023);
    plain(10'd0);
    // Negative offset below 0 wraps
    step(1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 1'b0, 10'd1020, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 10'd32, 1'b1, 1'b0);
    for (int unsigned i = 33; i <= 50; i++) plain(10'(i));
    // Ack beats Branch at 50
    step(1'b0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 10'd50, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 10'd50, 1'b0, 1'b1);

    // Restart from DONE; 9 plain instructions then Ack on the 10th
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cnt_start", {16'd0, CycleCnt}, 32'd0);
`endif
    for (int unsigned i = 1; i <= 9; i++) plain(10'(i));
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 10'd9, 1'b0, 1'b1);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cnt_ack", {16'd0, CycleCnt}, 32'd10);
`endif
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd9, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd9, 1'b0, 1'b1);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cnt_hold", {16'd0, CycleCnt}, 32'd10);
`endif
    step(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 10'd0, 1'b1, 1'b0);
`ifdef FETCH_CYCLE_COUNT_EN
    chk("cnt_clear", {16'd0, CycleCnt}, 32'd0);
`endif
    plain(10'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
